// File: rtl/estacionamiento_pkg.sv
`default_nettype none
// ============================================================================
// Module      : estacionamiento_pkg
// Description : Shared state encoding and default timing for the parking-lot
//               direction detector.
// Revision    : 1.0 - initial release
// ============================================================================
package estacionamiento_pkg;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_e1   = 3'd1;
    localparam logic [2:0] c_st_e2   = 3'd2;
    localparam logic [2:0] c_st_e3   = 3'd3;
    localparam logic [2:0] c_st_s1   = 3'd4;
    localparam logic [2:0] c_st_s2   = 3'd5;
    localparam logic [2:0] c_st_s3   = 3'd6;
    localparam logic [2:0] c_st_err  = 3'd7;

    localparam int c_debounce_def = 4;
    localparam int c_timeout_def  = 1000;

    // E* walk street->lot (entry), S* walk lot->street (exit)
    typedef enum logic [2:0] {
        ST_IDLE = c_st_idle,
        ST_E1   = c_st_e1,
        ST_E2   = c_st_e2,
        ST_E3   = c_st_e3,
        ST_S1   = c_st_s1,
        ST_S2   = c_st_s2,
        ST_S3   = c_st_s3,
        ST_ERR  = c_st_err
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/detector_sentido_sincronizador_antirrebote.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_antirrebote
// Description : 2-FF synchronizer followed by a consecutive-cycle debouncer
//               for one raw photo-barrier input.
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_antirrebote #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= r_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/detector_sentido.sv
`default_nettype none
// ============================================================================
// Module      : detector_sentido
// Description : Entry/exit direction detector for two series photo-barriers;
//               emits one-cycle up/down pulses for the occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module detector_sentido
    import estacionamiento_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_def,
    parameter int TIMEOUT_CYCLES  = c_timeout_def,
    parameter int CNT_W           = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic up,
    output logic down,
    output logic busy,
    output logic error
);

    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             w_fa;
    logic             w_fb;
    logic [1:0]       w_pair;
    logic             w_in_passage;
    logic             w_up_nxt;
    logic             w_down_nxt;
    estado_t          w_state_nxt;
    estado_t          r_state;
    logic [CNT_W-1:0] r_tmr;
    logic             r_up;
    logic             r_down;
    logic             r_busy;
    logic             r_error;

    sincronizador_antirrebote #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_filtro_a (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (sensor_a),
        .o_level (w_fa)
    );

    sincronizador_antirrebote #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_filtro_b (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (sensor_b),
        .o_level (w_fb)
    );

    assign w_pair       = {w_fa, w_fb};
    assign w_in_passage = (r_state != ST_IDLE) && (r_state != ST_ERR);

    always_comb begin
        w_state_nxt = r_state;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                case (w_pair)
                    2'b10:   w_state_nxt = ST_E1;
                    2'b01:   w_state_nxt = ST_S1;
                    2'b11:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_E1: begin
                case (w_pair)
                    2'b11:   w_state_nxt = ST_E2;
                    2'b00:   w_state_nxt = ST_IDLE;
                    2'b01:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_E2: begin
                case (w_pair)
                    2'b01:   w_state_nxt = ST_E3;
                    2'b10:   w_state_nxt = ST_E1;
                    2'b00:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_E3: begin
                case (w_pair)
                    2'b00: begin
                        w_state_nxt = ST_IDLE;
                        w_up_nxt    = 1'b1;
                    end
                    2'b11:   w_state_nxt = ST_E2;
                    2'b10:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_S1: begin
                case (w_pair)
                    2'b11:   w_state_nxt = ST_S2;
                    2'b00:   w_state_nxt = ST_IDLE;
                    2'b10:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_S2: begin
                case (w_pair)
                    2'b10:   w_state_nxt = ST_S3;
                    2'b01:   w_state_nxt = ST_S1;
                    2'b00:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_S3: begin
                case (w_pair)
                    2'b00: begin
                        w_state_nxt = ST_IDLE;
                        w_down_nxt  = 1'b1;
                    end
                    2'b11:   w_state_nxt = ST_S2;
                    2'b01:   w_state_nxt = ST_ERR;
                    default: ;
                endcase
            end
            ST_ERR: begin
                if (w_pair == 2'b00) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A genuine sensor transition wins over an expiring timer
        if (w_in_passage && (w_state_nxt == r_state) && (r_tmr == c_tmo_last)) begin
            w_state_nxt = ST_ERR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr <= '0;
        end else if (!w_in_passage || (w_state_nxt != r_state)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_up    <= w_up_nxt;
            r_down  <= w_down_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_error <= (w_state_nxt == ST_ERR);
        end
    end

    assign up    = r_up;
    assign down  = r_down;
    assign busy  = r_busy;
    assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_detector_sentido.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_sentido
// Description : Self-checking bench for detector_sentido (segment table, hand
//               corner sequences, randomized run against a lane-position model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_sentido;

    localparam int DEB = 4;
    localparam int TMO = 64;
    localparam int CW  = 10;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic up, down, busy, error;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    detector_sentido #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO),
        .CNT_W           (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .up       (up),
        .down     (down),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: car position along the lane ----------
    bit m_p1a, m_p2a, m_p1b, m_p2b;
    bit m_qa[$];
    bit m_qb[$];
    bit m_fa, m_fb;
    int m_pos;            // 0 idle, +k k-th step of entry, -k k-th step of exit
    bit m_err;
    int m_age;
    int m_prev_pos, m_now, m_new;
    bit m_prev_err, m_nu, m_nd, m_all;
    bit e_up, e_down, e_busy, e_err;

    function automatic int mag(input bit entrada, input bit a, input bit b);
        bit nearb, farb;
        nearb = entrada ? a : b;
        farb  = entrada ? b : a;
        return (nearb && !farb) ? 1 : (nearb && farb) ? 2 : farb ? 3 : 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_p1a = 0; m_p2a = 0; m_p1b = 0; m_p2b = 0;
            m_qa.delete(); m_qb.delete();
            m_fa = 0; m_fb = 0; m_pos = 0; m_err = 0; m_age = 0;
            e_up = 0; e_down = 0; e_busy = 0; e_err = 0;
        end else begin
            m_nu = 0; m_nd = 0; m_prev_pos = m_pos; m_prev_err = m_err;
            if (m_err) begin
                if (!m_fa && !m_fb) m_err = 0;
            end else if (m_pos == 0) begin
                if (m_fa && m_fb) m_err = 1;
                else if (m_fa)    m_pos = 1;
                else if (m_fb)    m_pos = -1;
            end else begin
                m_now = (m_pos > 0) ? m_pos : -m_pos;
                m_new = mag(m_pos > 0, m_fa, m_fb);
                if (m_new == 0 && m_now == 3) begin
                    if (m_pos > 0) m_nu = 1; else m_nd = 1;
                    m_pos = 0;
                end else if ((m_new - m_now <= 1) && (m_now - m_new <= 1)) begin
                    m_pos = (m_pos > 0) ? m_new : -m_new;
                end else begin
                    m_err = 1; m_pos = 0;
                end
                if (!m_err && m_pos != 0 && m_pos == m_prev_pos) begin
                    m_age++;
                    if (m_age >= TMO) begin m_err = 1; m_pos = 0; end
                end
            end
            if (m_pos != m_prev_pos || m_err != m_prev_err) m_age = 0;

            // filtered level follows once the last DEB synchronized samples all disagree
            m_qa.push_back(m_p2a); if (m_qa.size() > DEB) void'(m_qa.pop_front());
            m_qb.push_back(m_p2b); if (m_qb.size() > DEB) void'(m_qb.pop_front());
            m_all = (m_qa.size() == DEB);
            foreach (m_qa[i]) if (m_qa[i] == m_fa) m_all = 0;
            if (m_all) m_fa = !m_fa;
            m_all = (m_qb.size() == DEB);
            foreach (m_qb[i]) if (m_qb[i] == m_fb) m_all = 0;
            if (m_all) m_fb = !m_fb;
            m_p2a = m_p1a; m_p1a = sensor_a;
            m_p2b = m_p1b; m_p1b = sensor_b;

            e_up = m_nu; e_down = m_nd;
            e_busy = m_err || (m_pos != 0);
            e_err = m_err;
        end
    end

    bit prev_up = 0, prev_dn = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({up, down, busy, error} !== {e_up, e_down, e_busy, e_err}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got up/dn/busy/err=%b%b%b%b required=%b%b%b%b",
                         $time, up, down, busy, error, e_up, e_down, e_busy, e_err);
            end
            n_tests++;
            if ((up && down) || (up && prev_up) || (down && prev_dn)) begin
                n_fail++;
                $display("FAIL pulse_shape t=%0t got up=%b down=%b prev_up=%b prev_dn=%b required single exclusive pulses",
                         $time, up, down, prev_up, prev_dn);
            end
            prev_up = up;
            prev_dn = down;
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        bit    a;
        bit    b;
        int    len;
        int    n_up;
        int    n_dn;
        bit    busy;
        bit    err;
        string name;
    } seg_t;

    seg_t tbl[$];

    function automatic seg_t mk(input bit a, input bit b, input int len, input int nu,
                                input int nd, input bit bz, input bit er, input string nm);
        seg_t s;
        s.a = a; s.b = b; s.len = len; s.n_up = nu; s.n_dn = nd;
        s.busy = bz; s.err = er; s.name = nm;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input int got, input int req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic run_seg(input seg_t s);
        int nu, nd;
        nu = 0; nd = 0;
        sensor_a = s.a; sensor_b = s.b;
        for (int k = 0; k < s.len; k++) begin
            tick();
            nu += int'(up);
            nd += int'(down);
        end
        check({s.name, "_up"},    nu, s.n_up);
        check({s.name, "_down"},  nd, s.n_dn);
        check({s.name, "_busy"},  int'(busy),  int'(s.busy));
        check({s.name, "_error"}, int'(error), int'(s.err));
    endtask

    int first, cnt, r, len;

    initial begin
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 0, "ent_a"));
        tbl.push_back(mk(1, 1, 20, 0, 0, 1, 0, "ent_ab"));
        tbl.push_back(mk(0, 1, 20, 0, 0, 1, 0, "ent_b"));
        tbl.push_back(mk(0, 0, 20, 1, 0, 0, 0, "ent_done"));
        tbl.push_back(mk(0, 1, 20, 0, 0, 1, 0, "sal_b"));
        tbl.push_back(mk(1, 1, 20, 0, 0, 1, 0, "sal_ba"));
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 0, "sal_a"));
        tbl.push_back(mk(0, 0, 20, 0, 1, 0, 0, "sal_done"));
        tbl.push_back(mk(1, 0,  3, 0, 0, 0, 0, "glitch"));
        tbl.push_back(mk(0, 0, 20, 0, 0, 0, 0, "glitch_idle"));
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 0, "abort_a"));
        tbl.push_back(mk(1, 1, 20, 0, 0, 1, 0, "abort_ab"));
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 0, "abort_back"));
        tbl.push_back(mk(0, 0, 20, 0, 0, 0, 0, "abort_idle"));
        tbl.push_back(mk(1, 1, 20, 0, 0, 1, 1, "both_rise"));
        tbl.push_back(mk(0, 0, 20, 0, 0, 0, 0, "both_clear"));
        tbl.push_back(mk(1, 0, 100, 0, 0, 1, 1, "timeout"));
        tbl.push_back(mk(0, 0, 20, 0, 0, 0, 0, "timeout_clear"));
        tbl.push_back(mk(0, 1, 20, 0, 0, 1, 0, "wrong_s1"));
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 1, "wrong_jump"));
        tbl.push_back(mk(0, 0, 20, 0, 0, 0, 0, "wrong_clear"));
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 0, "osc_a"));
        tbl.push_back(mk(1, 1, 20, 0, 0, 1, 0, "osc_ab"));
        tbl.push_back(mk(1, 0, 20, 0, 0, 1, 0, "osc_a2"));
        tbl.push_back(mk(1, 1, 20, 0, 0, 1, 0, "osc_ab2"));
        tbl.push_back(mk(0, 1, 20, 0, 0, 1, 0, "osc_b"));
        tbl.push_back(mk(0, 0, 20, 1, 0, 0, 0, "osc_done"));

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({up, down, busy, error}), 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i]);

        // completion pulse latency from the raw B falling edge
        for (int i = 0; i < 3; i++) run_seg(tbl[i]);
        sensor_a = 0; sensor_b = 0;
        first = -1; cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (up) begin cnt++; if (first < 0) first = k; end
        end
        check("up_latency", first, 7);
        check("up_count", cnt, 1);

        // timeout edge and error-clear latency
        sensor_a = 1;
        first = -1;
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (error && first < 0) first = k;
        end
        check("timeout_cycle", first, 7 + TMO);
        sensor_a = 0;
        first = -1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (!error && first < 0) first = k;
        end
        check("error_clear_cycle", first, 7);

        // glitch must never raise busy
        sensor_a = 1; tick(); tick(); tick();
        sensor_a = 0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cnt += int'(busy);
        end
        check("glitch_busy_cycles", cnt, 0);

        // asynchronous reset while in E3
        for (int i = 0; i < 3; i++) run_seg(tbl[i]);
        #2;
        reset_n  = 1'b0;
        sensor_a = 0; sensor_b = 0;
        #1;
        check("reset_mid_outputs", int'({up, down, busy, error}), 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin tick(); cnt += int'(up); end
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin tick(); cnt += int'(up) + int'(busy); end
        check("reset_no_pulse", cnt, 0);
        for (int i = 0; i < 4; i++) run_seg(tbl[i]);

        // randomized segments checked cycle by cycle against the model
        for (int s = 0; s < 220; s++) begin
            r = $urandom_range(0, 3);
            sensor_a = r[1];
            sensor_b = r[0];
            len = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 12) : $urandom_range(13, 90);
            repeat (len) tick();
        end
        sensor_a = 0; sensor_b = 0;
        repeat (30) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
